// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data memory responder.
// Access sizes and FSM states.
package data_mem_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/data_mem_responder_align.sv
// Byte-lane steering between the request and the 32-bit storage word.
// Store side: byte enables and replicated data; load side: extract and extend.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        byte_en  = 4'b0000;
        wdata_sh = 32'd0;
        rdata    = 32'd0;
        ld_byte  = 8'(rword >> {lane, 3'b000});
        ld_half  = lane[1] ? rword[31:16] : rword[15:0];
        case (size)
            SIZE_BYTE: begin
                byte_en  = 4'b0001 << lane;
                wdata_sh = {4{wdata[7:0]}};
                rdata    = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            end
            SIZE_HALF: begin
                byte_en  = lane[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                rdata    = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            end
            SIZE_WORD: begin
                byte_en  = 4'b1111;
                wdata_sh = wdata;
                rdata    = rword;
            end
            default: begin
                byte_en  = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: word storage, wait states, one-cycle response pulse.
// Stores commit and load data is captured on the edge that enters RESP.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int IW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_unsigned;

    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_unsigned;

    logic        accept;
    logic        enter_resp;
    logic        err;
    logic        commit;
    logic [IW-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rword;
    logic [3:0]  byte_en;
    logic [31:0] wdata_sh;
    logic [31:0] ld_data;

    logic        resp_error_q;
    logic [31:0] resp_rdata_q;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

    // With zero latency RESP is entered on the accept edge itself,
    // so the live request must be used before it is latched.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_write    = req_write;
            cur_addr     = req_addr;
            cur_wdata    = req_wdata;
            cur_size     = req_size;
            cur_unsigned = req_unsigned;
        end else begin
            cur_write    = lat_write;
            cur_addr     = lat_addr;
            cur_wdata    = lat_wdata;
            cur_size     = lat_size;
            cur_unsigned = lat_unsigned;
        end
    end

    always_comb begin
        err = (cur_size == SIZE_RSVD)
            | ((cur_size == SIZE_HALF) && cur_addr[0])
            | ((cur_size == SIZE_WORD) && (cur_addr[1:0] != 2'b00))
            | (cur_addr[31:2] >= 30'(DEPTH_WORDS));
    end

    assign idx    = cur_addr[IW+1:2];
    assign rword  = mem[idx];
    assign commit = enter_resp && cur_write && !err && rst;

    mem_lane_align u_align (
        .lane        (cur_addr[1:0]),
        .size        (cur_size),
        .is_unsigned (cur_unsigned),
        .wdata       (cur_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_sh    (wdata_sh),
        .rdata       (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (LATENCY == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(LAST)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            lat_write    <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_size     <= SIZE_BYTE;
            lat_unsigned <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_write    <= req_write;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
            end
            if (enter_resp) begin
                resp_error_q <= err;
                resp_rdata_q <= (!cur_write && !err) ? ld_data : 32'd0;
            end else begin
                resp_error_q <= 1'b0;
                resp_rdata_q <= 32'd0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

endmodule
